// File: rtl/order_book_pkg.sv
// Shared definitions for the order-book datapath: price width, the empty-slot
// markers the matching engine recognises, the legal price range, the order
// generator FSM states, and a saturating price clamp.
//
// No ports (package).
package order_book_pkg;

  localparam int PRICE_W = 8;

  // An empty slot in the engine's shift window is a bid of 0 and an ask of FF.
  // Real orders are kept strictly inside these so they never look empty.
  localparam logic [PRICE_W-1:0] EMPTY_BID = 8'h00;
  localparam logic [PRICE_W-1:0] EMPTY_ASK = 8'hFF;

  localparam logic [PRICE_W-1:0] PRICE_MIN = 8'd1;
  localparam logic [PRICE_W-1:0] PRICE_MAX = 8'd254;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  // Saturate a 10-bit signed intermediate price into PRICE_MIN..PRICE_MAX.
  function automatic logic [PRICE_W-1:0] clamp_price(input logic signed [9:0] p);
    logic [PRICE_W-1:0] result;
    if (p < 10'sd1) begin
      result = PRICE_MIN;
    end else if (p > 10'sd254) begin
      result = PRICE_MAX;
    end else begin
      result = p[PRICE_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/order_generator_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16/14/13/11.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset (loads the seed)
//   advance    in   step the register on this edge
//   value_next out  value the register takes on the next advance
//
// The next value is exposed rather than the current one because consumers
// derive their fields from the freshly stepped state on the same edge.
// A seed of zero would lock the register up, so it is replaced by 1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value_next
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] value;

  // Feedback bit shifted into the LSB.
  always_comb begin
    value_next = {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  end

  // State register; only moves when the consumer asks for a new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= SEED_EFF;
    end else if (advance) begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/order_generator.sv
// order_generator: pseudo-random order-stream source for the matching engine.
// Emits buy/sell price pairs around a random-walk mid price at most once every
// RATE_DIV cycles, either continuously or as a fixed-length burst, and drives
// the empty markers (bid 00, ask FF) on every cycle without an order.
//
// Optional build macro ORDER_GEN_CROSS_INJECT_EN: every 16th order is forced
// to buy = sell = new mid so the engine is guaranteed to see a match.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   start        in   single-cycle request to begin generating
//   stop         in   single-cycle abort back to idle (beats start and orders)
//   burst_len    in   [7:0] sampled at start; 0 = continuous, N = N orders
//   buy_price    out  [7:0] registered bid; 0 when no order
//   sell_price   out  [7:0] registered ask; FF when no order
//   order_strobe out  high for the cycle an order is presented
//   busy         out  high while running
//   mid_price    out  [7:0] current random-walk mid
//   order_count  out  [15:0] orders emitted since reset, wrapping
module order_generator
  import order_book_pkg::*;
#(
  parameter int          RATE_DIV    = 4,
  parameter int          SPREAD_BITS = 3,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          MID_INIT    = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  burst_len,
  output logic [7:0]  buy_price,
  output logic [7:0]  sell_price,
  output logic        order_strobe,
  output logic        busy,
  output logic [7:0]  mid_price,
  output logic [15:0] order_count
);

  localparam logic [7:0] RATE_LAST = 8'(RATE_DIV - 1);
  localparam logic [7:0] MID_RESET = 8'(MID_INIT);

  gen_state_t  state;
  gen_state_t  state_next;
  logic [7:0]  rate_cnt;
  logic [7:0]  remaining;
  logic        continuous;
  logic        order_due;

  logic [15:0] lfsr_n;
  logic        lfsr_unused;

  logic signed [9:0] step;
  logic signed [9:0] mid_sum;
  logic signed [9:0] buy_raw;
  logic signed [9:0] sell_raw;
  logic [9:0]        off_buy;
  logic [9:0]        off_sell;
  logic [7:0]        new_mid;
  logic [7:0]        buy_next;
  logic [7:0]        sell_next;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .advance   (order_due),
    .value_next(lfsr_n)
  );

  // Only the low fields of the LFSR are consumed; fold the rest away.
  assign lfsr_unused = ^lfsr_n;

  assign busy = (state == RUN);

  // Next-state logic. Stop wins over start and over a due order, so a stop
  // edge never emits. A burst leaves RUN on the same edge as its last order.
  always_comb begin
    state_next = state;
    order_due  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (rate_cnt == RATE_LAST) begin
          order_due = 1'b1;
          if (!continuous && remaining == 8'd1) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Price datapath, all fields taken from the stepped LFSR value. Arithmetic
  // is 10-bit signed so mid +/- offset can go past 0..255 before clamping.
  always_comb begin
    step = 10'sd0;
    case (lfsr_n[1:0])
      2'b01:   step = 10'sd1;
      2'b10:   step = -10'sd1;
      default: step = 10'sd0;
    endcase

    off_buy  = 10'(lfsr_n[2 +: SPREAD_BITS]) + 10'd1;
    off_sell = 10'(lfsr_n[2 + SPREAD_BITS +: SPREAD_BITS]) + 10'd1;

    mid_sum  = $signed({2'b00, mid_price}) + step;
    new_mid  = clamp_price(mid_sum);
    buy_raw  = $signed({2'b00, new_mid}) - $signed(off_buy);
    sell_raw = $signed({2'b00, new_mid}) + $signed(off_sell);

    buy_next  = EMPTY_BID;
    sell_next = EMPTY_ASK;
    if (order_due) begin
      buy_next  = clamp_price(buy_raw);
      sell_next = clamp_price(sell_raw);
`ifdef ORDER_GEN_CROSS_INJECT_EN
      // Every 16th order crosses at the mid so the engine must match it.
      if (order_count[3:0] == 4'hF) begin
        buy_next  = new_mid;
        sell_next = new_mid;
      end
`endif
    end
  end

  // Registered state. Output prices fall back to the empty markers on every
  // non-order edge; mid and the LFSR only move on order edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rate_cnt     <= 8'd0;
      remaining    <= 8'd0;
      continuous   <= 1'b0;
      buy_price    <= EMPTY_BID;
      sell_price   <= EMPTY_ASK;
      order_strobe <= 1'b0;
      mid_price    <= MID_RESET;
      order_count  <= 16'd0;
    end else begin
      state        <= state_next;
      buy_price    <= buy_next;
      sell_price   <= sell_next;
      order_strobe <= order_due;

      if (order_due) begin
        mid_price   <= new_mid;
        order_count <= order_count + 16'd1;
        if (!continuous) begin
          remaining <= remaining - 8'd1;
        end
      end

      if (state == IDLE) begin
        rate_cnt <= 8'd0;
        if (start && !stop) begin
          remaining  <= burst_len;
          continuous <= (burst_len == 8'd0);
        end
      end else if (stop || rate_cnt == RATE_LAST) begin
        rate_cnt <= 8'd0;
      end else begin
        rate_cnt <= rate_cnt + 8'd1;
      end
    end
  end

endmodule
